// File: rtl/accel_pkg.sv
// accel_pkg: device constants, init table and state types for the accelerometer sequencer.
package accel_pkg;

  localparam logic [7:0] DEV_W    = 8'hA6;
  localparam logic [7:0] DEV_R    = 8'hA7;
  localparam logic [7:0] DATA_REG = 8'h32;
  localparam int         N_INIT   = 3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    GAP,
    WAIT_TICK,
    FAULT
  } seq_state_t;

  typedef enum logic [1:0] {
    STEP_INIT,
    STEP_PTR,
    STEP_READ
  } step_t;

  // Register address of init table entry idx.
  function automatic logic [7:0] init_reg(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h2C;
      2'd1:    return 8'h31;
      default: return 8'h2D;
    endcase
  endfunction

  // Value written to register init_reg(idx).
  function automatic logic [7:0] init_val(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h0A;
      2'd1:    return 8'h0B;
      default: return 8'h08;
    endcase
  endfunction

endpackage

// File: rtl/accel_i2c_sequencer_if.sv
// accel_i2c_sequencer_if: command/response bundle between the sequencer and the I2C bus master.
interface accel_i2c_sequencer_if;

  logic        I2C_en;
  logic        I2C_wr;
  logic [31:0] I2C_wdata;
  logic [31:0] I2C_rdata;
  logic [4:0]  I2C_NM;
  logic        I2C_done;
  logic        I2C_error;
  logic [23:0] ReadData;

  // The sequencer issues commands.
  modport master (
    output I2C_en, I2C_wr, I2C_wdata, I2C_rdata, I2C_NM,
    input  I2C_done, I2C_error, ReadData
  );

  // The I2C bus master executes them.
  modport slave (
    input  I2C_en, I2C_wr, I2C_wdata, I2C_rdata, I2C_NM,
    output I2C_done, I2C_error, ReadData
  );

endinterface

// File: rtl/sample_fifo.sv
// sample_fifo: small synchronous FIFO holding {X,Y,Z} samples for the USB side.
// A push while full is accepted only when a pop happens in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/accel_i2c_sequencer.sv
// accel_i2c_sequencer: runs the accelerometer init table over I2C, then polls X/Y/Z
// on a periodic tick, with per-transaction retry/timeout and a sample FIFO.
module accel_i2c_sequencer
  import accel_pkg::*;
#(
  parameter int SAMPLE_DIV = 100000,
  parameter int MAX_RETRY  = 3,
  parameter int TIMEOUT    = 4095,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk_in,
  input  logic                         reset,
  input  logic                         start,
  accel_i2c_sequencer_if.master        bus,
  output logic [23:0]                  sample_data,
  output logic                         sample_valid,
  input  logic                         sample_ready,
  output logic                         init_done,
  output logic                         fault,
  output logic [7:0]                   overflow_cnt
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);
  localparam int RTY_W  = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);
  localparam logic [RTY_W-1:0]  RTY_MAX   = RTY_W'(MAX_RETRY);
  localparam logic [1:0]        LAST_INIT = 2'(N_INIT - 1);

  seq_state_t        state, state_n;
  step_t             step, step_n;
  logic [1:0]        init_idx, init_idx_n;
  logic [RTY_W-1:0]  retry, retry_n;
  logic [TMO_W-1:0]  tmo_cnt, tmo_cnt_n;
  logic              err, err_n;
  logic [23:0]       rd_q, rd_n;
  logic              init_done_n;
  logic              fault_n;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_n;
  logic              tick_pend, tick_pend_n;
  logic              tick;
  logic              restart;
  logic              pend_clear;
  logic              push_req;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  assign sample_valid = !fifo_empty;
  assign pop          = sample_valid && sample_ready;
  assign drop         = push_req && fifo_full && !pop;

  // Register all sequencer state; reset returns to IDLE with everything cleared.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state        <= IDLE;
      step         <= STEP_INIT;
      init_idx     <= '0;
      retry        <= '0;
      tmo_cnt      <= '0;
      err          <= 1'b0;
      rd_q         <= '0;
      init_done    <= 1'b0;
      fault        <= 1'b0;
      tick_cnt     <= '0;
      tick_pend    <= 1'b0;
      overflow_cnt <= '0;
    end else begin
      state     <= state_n;
      step      <= step_n;
      init_idx  <= init_idx_n;
      retry     <= retry_n;
      tmo_cnt   <= tmo_cnt_n;
      err       <= err_n;
      rd_q      <= rd_n;
      init_done <= init_done_n;
      fault     <= fault_n;
      tick_cnt  <= tick_cnt_n;
      tick_pend <= tick_pend_n;
      if (drop && (overflow_cnt != 8'hFF)) overflow_cnt <= overflow_cnt + 8'd1;
    end
  end

  // Next-state logic: issue, one-cycle gap to reset the master, then retry/advance/fault.
  always_comb begin
    state_n     = state;
    step_n      = step;
    init_idx_n  = init_idx;
    retry_n     = retry;
    tmo_cnt_n   = '0;
    err_n       = err;
    rd_n        = rd_q;
    init_done_n = init_done;
    fault_n     = fault;
    push_req    = 1'b0;
    pend_clear  = 1'b0;
    restart     = 1'b0;

    case (state)
      IDLE, FAULT: begin
        if (start) begin
          restart     = 1'b1;
          state_n     = ISSUE;
          step_n      = STEP_INIT;
          init_idx_n  = '0;
          retry_n     = '0;
          fault_n     = 1'b0;
          init_done_n = 1'b0;
        end
      end
      ISSUE: begin
        if (bus.I2C_done) begin
          state_n = GAP;
          err_n   = bus.I2C_error;
          rd_n    = bus.ReadData;
        end else if (tmo_cnt == TMO_LAST) begin
          state_n = GAP;
          err_n   = 1'b1;
        end else begin
          tmo_cnt_n = tmo_cnt + 1'b1;
        end
      end
      GAP: begin
        if (err) begin
          if (retry < RTY_MAX) begin
            retry_n = retry + 1'b1;
            state_n = ISSUE;
          end else begin
            state_n = FAULT;
            fault_n = 1'b1;
          end
        end else begin
          retry_n = '0;
          case (step)
            STEP_INIT: begin
              if (init_idx == LAST_INIT) begin
                init_done_n = 1'b1;
                state_n     = WAIT_TICK;
              end else begin
                init_idx_n = init_idx + 1'b1;
                state_n    = ISSUE;
              end
            end
            STEP_PTR: begin
              step_n  = STEP_READ;
              state_n = ISSUE;
            end
            default: begin
              push_req = 1'b1;
              state_n  = WAIT_TICK;
            end
          endcase
        end
      end
      WAIT_TICK: begin
        if (tick_pend) begin
          pend_clear = 1'b1;
          step_n     = STEP_PTR;
          state_n    = ISSUE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Sample tick: free-runs only after init, latching a single pending request.
  always_comb begin
    tick       = init_done && (tick_cnt == TICK_LAST);
    tick_cnt_n = (!init_done || tick) ? '0 : tick_cnt + 1'b1;
    if (restart)         tick_pend_n = 1'b0;
    else if (tick)       tick_pend_n = 1'b1;
    else if (pend_clear) tick_pend_n = 1'b0;
    else                 tick_pend_n = tick_pend;
  end

  // Command decode: the master only sees a non-zero command while ISSUE holds it.
  always_comb begin
    bus.I2C_en    = 1'b0;
    bus.I2C_wr    = 1'b0;
    bus.I2C_wdata = '0;
    bus.I2C_rdata = '0;
    bus.I2C_NM    = '0;
    if (state == ISSUE) begin
      bus.I2C_en = 1'b1;
      case (step)
        STEP_INIT: begin
          bus.I2C_NM    = 5'd3;
          bus.I2C_wdata = {8'h00, DEV_W, init_reg(init_idx), init_val(init_idx)};
        end
        STEP_PTR: begin
          bus.I2C_NM    = 5'd2;
          bus.I2C_wdata = {16'h0000, DEV_W, DATA_REG};
        end
        default: begin
          bus.I2C_wr    = 1'b1;
          bus.I2C_NM    = 5'd4;
          bus.I2C_rdata = {DEV_R, 24'hFFFFFF};
        end
      endcase
    end
  end

  sample_fifo #(
    .WIDTH(24),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk_in),
    .reset(reset),
    .push (push_req),
    .pop  (pop),
    .din  (rd_q),
    .dout (sample_data),
    .full (fifo_full),
    .empty(fifo_empty)
  );

endmodule

// File: tb/tb_accel_i2c_sequencer.sv
// tb_accel_i2c_sequencer: directed bench with a small I2C master model answering each transaction.
module tb_accel_i2c_sequencer;

  localparam int SAMPLE_DIV = 60;
  localparam int MAX_RETRY  = 3;
  localparam int TIMEOUT    = 20;
  localparam int FIFO_DEPTH = 4;
  localparam int WAIT_LIMIT = 2 * SAMPLE_DIV + 50;

  typedef struct {
    logic        wr;
    logic [4:0]  nm;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;
    logic        err;
    logic [23:0] rd;
    logic        back;
  } txn_t;

  logic        clk_in;
  logic        reset;
  logic        start;
  logic [23:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        init_done;
  logic        fault;
  logic [7:0]  overflow_cnt;

  int checks = 0;
  int errors = 0;

  accel_i2c_sequencer_if bus();

  accel_i2c_sequencer #(
    .SAMPLE_DIV(SAMPLE_DIV),
    .MAX_RETRY (MAX_RETRY),
    .TIMEOUT   (TIMEOUT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .start       (start),
    .bus         (bus.master),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .init_done   (init_done),
    .fault       (fault),
    .overflow_cnt(overflow_cnt)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic txn_t mkInit(input logic [31:0] wdata, input logic err, input logic back);
    txn_t t;
    t.wr = 1'b0; t.nm = 5'd3; t.wdata = wdata; t.rdata = 32'h0;
    t.delay = 1; t.err = err; t.rd = 24'h0; t.back = back;
    return t;
  endfunction

  function automatic txn_t mkPtr(input logic err, input logic back);
    txn_t t;
    t.wr = 1'b0; t.nm = 5'd2; t.wdata = 32'h0000A632; t.rdata = 32'h0;
    t.delay = 0; t.err = err; t.rd = 24'h0; t.back = back;
    return t;
  endfunction

  function automatic txn_t mkRead(input logic [23:0] rd);
    txn_t t;
    t.wr = 1'b1; t.nm = 5'd4; t.wdata = 32'h0; t.rdata = 32'hA7FFFFFF;
    t.delay = 2; t.err = 1'b0; t.rd = rd; t.back = 1'b0;
    return t;
  endfunction

  // Master model: wait for I2C_en, check the command, answer after t.delay cycles.
  // Returns on the gap cycle (or one cycle later when a back-to-back reissue is expected).
  task automatic applyStimulus(input txn_t t);
    int waited = 0;
    while (bus.I2C_en !== 1'b1 && waited < WAIT_LIMIT) begin
      @(negedge clk_in);
      waited++;
    end
    if (bus.I2C_en !== 1'b1) begin
      checkOutput("en_wait", {31'h0, bus.I2C_en}, 32'h1);
      return;
    end
    checkOutput("wr", {31'h0, bus.I2C_wr}, {31'h0, t.wr});
    checkOutput("nm", {27'h0, bus.I2C_NM}, {27'h0, t.nm});
    checkOutput("wdata", bus.I2C_wdata, t.wdata);
    checkOutput("rdata", bus.I2C_rdata, t.rdata);
    repeat (t.delay) begin
      @(negedge clk_in);
      checkOutput("en_held", {31'h0, bus.I2C_en}, 32'h1);
    end
    bus.I2C_done  = 1'b1;
    bus.I2C_error = t.err;
    bus.ReadData  = t.rd;
    @(negedge clk_in);
    bus.I2C_done  = 1'b0;
    bus.I2C_error = 1'b0;
    bus.ReadData  = 24'h0;
    checkOutput("gap_en", {31'h0, bus.I2C_en}, 32'h0);
    if (t.back) begin
      @(negedge clk_in);
      checkOutput("reissue_en", {31'h0, bus.I2C_en}, 32'h1);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk_in);
    start = 1'b0;
  endtask

  txn_t vec [7];
  logic [23:0] ovf_exp [4];

  initial begin
    int en_cnt;

    vec[0] = mkInit(32'h00A62C0A, 1'b0, 1'b1);
    vec[1] = mkInit(32'h00A6310B, 1'b1, 1'b1);
    vec[2] = mkInit(32'h00A6310B, 1'b1, 1'b1);
    vec[3] = mkInit(32'h00A6310B, 1'b0, 1'b1);
    vec[4] = mkInit(32'h00A62D08, 1'b0, 1'b0);
    vec[5] = mkPtr(1'b0, 1'b1);
    vec[6] = mkRead(24'h123456);

    reset = 1'b1; start = 1'b0; sample_ready = 1'b0;
    bus.I2C_done = 1'b0; bus.I2C_error = 1'b0; bus.ReadData = 24'h0;
    repeat (3) @(negedge clk_in);

    // Reset state
    checkOutput("rst_en", {31'h0, bus.I2C_en}, 32'h0);
    checkOutput("rst_wr", {31'h0, bus.I2C_wr}, 32'h0);
    checkOutput("rst_wdata", bus.I2C_wdata, 32'h0);
    checkOutput("rst_rdata", bus.I2C_rdata, 32'h0);
    checkOutput("rst_nm", {27'h0, bus.I2C_NM}, 32'h0);
    checkOutput("rst_valid", {31'h0, sample_valid}, 32'h0);
    checkOutput("rst_data", {8'h0, sample_data}, 32'h0);
    checkOutput("rst_init_done", {31'h0, init_done}, 32'h0);
    checkOutput("rst_fault", {31'h0, fault}, 32'h0);
    checkOutput("rst_ovf", {24'h0, overflow_cnt}, 32'h0);
    reset = 1'b0;
    @(negedge clk_in);

    // Init with two NACKs on INIT 1
    pulseStart();
    checkOutput("start_en", {31'h0, bus.I2C_en}, 32'h1);
    for (int i = 0; i < 5; i++) begin
      if (i == 4) checkOutput("init_done_early", {31'h0, init_done}, 32'h0);
      applyStimulus(vec[i]);
    end
    @(negedge clk_in);
    checkOutput("init_done", {31'h0, init_done}, 32'h1);
    checkOutput("idle_en", {31'h0, bus.I2C_en}, 32'h0);

    // First sample
    applyStimulus(vec[5]);
    applyStimulus(vec[6]);
    checkOutput("valid_d1", {31'h0, sample_valid}, 32'h0);
    @(negedge clk_in);
    checkOutput("valid_d2", {31'h0, sample_valid}, 32'h1);
    checkOutput("sample", {8'h0, sample_data}, 32'h00123456);
    sample_ready = 1'b1;
    @(negedge clk_in);
    sample_ready = 1'b0;
    checkOutput("valid_pop", {31'h0, sample_valid}, 32'h0);

    // Overflow: six samples into a four-deep FIFO with no consumer
    for (int i = 0; i < 6; i++) begin
      applyStimulus(mkPtr(1'b0, 1'b1));
      applyStimulus(mkRead(24'hA00001 + 24'(i)));
    end
    @(negedge clk_in);
    checkOutput("ovf_cnt", {24'h0, overflow_cnt}, 32'h2);
    for (int i = 0; i < 4; i++) ovf_exp[i] = 24'hA00001 + 24'(i);
    for (int i = 0; i < 4; i++) begin
      checkOutput("ovf_valid", {31'h0, sample_valid}, 32'h1);
      checkOutput("ovf_order", {8'h0, sample_data}, {8'h0, ovf_exp[i]});
      sample_ready = 1'b1;
      @(negedge clk_in);
    end
    sample_ready = 1'b0;
    checkOutput("ovf_drained", {31'h0, sample_valid}, 32'h0);

    // Fault: NACK every attempt of a PTR transaction
    for (int a = 0; a < 4; a++) applyStimulus(mkPtr(1'b1, (a < 3) ? 1'b1 : 1'b0));
    @(negedge clk_in);
    checkOutput("fault_set", {31'h0, fault}, 32'h1);
    en_cnt = 0;
    repeat (5) begin
      @(negedge clk_in);
      if (bus.I2C_en === 1'b1) en_cnt++;
    end
    checkOutput("fault_en_low", en_cnt, 0);

    // Restart from FAULT, then time out once and NACK three times
    pulseStart();
    checkOutput("restart_fault", {31'h0, fault}, 32'h0);
    checkOutput("restart_init_done", {31'h0, init_done}, 32'h0);
    checkOutput("restart_wdata", bus.I2C_wdata, 32'h00A62C0A);
    en_cnt = (bus.I2C_en === 1'b1) ? 1 : 0;
    while (bus.I2C_en === 1'b1 && en_cnt < TIMEOUT + 10) begin
      @(negedge clk_in);
      if (bus.I2C_en === 1'b1) en_cnt++;
    end
    checkOutput("timeout_len", en_cnt, TIMEOUT);
    @(negedge clk_in);
    checkOutput("timeout_reissue", {31'h0, bus.I2C_en}, 32'h1);
    applyStimulus(mkInit(32'h00A62C0A, 1'b1, 1'b1));
    applyStimulus(mkInit(32'h00A62C0A, 1'b1, 1'b1));
    applyStimulus(mkInit(32'h00A62C0A, 1'b1, 1'b0));
    @(negedge clk_in);
    checkOutput("timeout_fault", {31'h0, fault}, 32'h1);

    // Clean restart through the whole init table
    pulseStart();
    applyStimulus(mkInit(32'h00A62C0A, 1'b0, 1'b1));
    applyStimulus(mkInit(32'h00A6310B, 1'b0, 1'b1));
    applyStimulus(mkInit(32'h00A62D08, 1'b0, 1'b0));
    @(negedge clk_in);
    checkOutput("reinit_done", {31'h0, init_done}, 32'h1);

    // Reset while a transaction is in flight
    en_cnt = 0;
    while (bus.I2C_en !== 1'b1 && en_cnt < WAIT_LIMIT) begin
      @(negedge clk_in);
      en_cnt++;
    end
    checkOutput("ptr_before_reset", {31'h0, bus.I2C_en}, 32'h1);
    reset = 1'b1;
    @(negedge clk_in);
    checkOutput("reset_en_drop", {31'h0, bus.I2C_en}, 32'h0);
    checkOutput("reset_init_done", {31'h0, init_done}, 32'h0);
    reset = 1'b0;
    @(negedge clk_in);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
